// File: rtl/dmem_pkg.sv
// dmem_pkg: shared arbiter state encoding and default memory geometry.
package dmem_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    typedef enum logic {ARB, LOCK1} arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's valid/ready request channel plus its read response.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a contended cycle goes to the port that was not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);
    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core (m0) and a DMA/debug master (m1),
// round-robin with an optional capped m1 burst lock.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    input  logic              m1_lock_i,
    output logic              dmem_wen_o,
    output logic [ADDR_W-1:0] dmem_waddr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic              dmem_ren_o,
    output logic [ADDR_W-1:0] dmem_raddr_o,
    input  logic [DATA_W-1:0] dmem_rdata_i
);
    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);
    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        arb_gnt, gnt;
    logic              hold, op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              rv0_q, rv1_q;
    logic [DATA_W-1:0] rd0_q, rd1_q;

    rr_arb2 u_rr (
        .req_i       ({m1.valid, m0.valid}),
        .last_grant_i(last_q),
        .gnt_o       (arb_gnt)
    );

    // Any failed hold condition drops back to round-robin, which favours m0 because m1 was last.
    always_comb begin
        hold     = state_q == LOCK1 && m1.valid && m1_lock_i && cnt_q < LOCK_MAX_C;
        gnt      = !rst_n ? 2'b00 : hold ? 2'b10 : arb_gnt;
        state_d  = ARB;
        cnt_d    = '0;
        last_d   = |gnt ? gnt[1] : last_q;
        if (hold) begin
            state_d = LOCK1;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (gnt[1] && m1_lock_i) begin
            state_d = LOCK1;
            cnt_d   = 8'd1;
        end
        op_we    = gnt[1] ? m1.we : m0.we;
        op_addr  = gnt[1] ? m1.addr : m0.addr;
        op_wdata = gnt[1] ? m1.wdata : m0.wdata;
    end

    assign m0.ready     = gnt[0];
    assign m1.ready     = gnt[1];
    assign m0.rvalid    = rv0_q;
    assign m1.rvalid    = rv1_q;
    assign m0.rdata     = rd0_q;
    assign m1.rdata     = rd1_q;
    assign dmem_wen_o   = |gnt & op_we;
    assign dmem_waddr_o = dmem_wen_o ? op_addr : '0;
    assign dmem_wdata_o = dmem_wen_o ? op_wdata : '0;
    assign dmem_ren_o   = |gnt & ~op_we;
    assign dmem_raddr_o = dmem_ren_o ? op_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rv0_q   <= gnt[0] & ~op_we;
            rv1_q   <= gnt[1] & ~op_we;
            if (gnt[0] & ~op_we) rd0_q <= dmem_rdata_i;
            if (gnt[1] & ~op_we) rd1_q <= dmem_rdata_i;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: grant-table vectors, directed corner sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LM = 4;
    typedef struct {
        logic       v0;
        logic       v1;
        logic       lk;
        logic [1:0] g;
    } vec_t;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m1_lock = 1'b0;
    logic          wen, ren;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, rdata;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] mmem [int];
    int            vecs = 0;
    int            errs = 0;
    bit            in_lock, last;
    int            cnt;
    logic          ev0, ev1;
    logic [DW-1:0] ed0, ed1;
    vec_t          tbl [18];

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .m1_lock_i(m1_lock),
        .dmem_wen_o(wen), .dmem_waddr_o(waddr), .dmem_wdata_o(wdata),
        .dmem_ren_o(ren), .dmem_raddr_o(raddr), .dmem_rdata_i(rdata)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) if (wen) mem[waddr] <= wdata;
    assign rdata = mem[raddr];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string nm, input logic r0, input logic r1, input logic w,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic r,
                           input logic [AW-1:0] ra);
        @(negedge clk);
        chk(nm, {m0.ready, m1.ready, wen, waddr, wdata, ren, raddr}, {r0, r1, w, wa, wd, r, ra});
    endtask

    task automatic req(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        if (p == 0) begin
            m0.valid = v; m0.we = w; m0.addr = a; m0.wdata = d;
        end else begin
            m1.valid = v; m1.we = w; m1.addr = a; m1.wdata = d;
        end
    endtask

    task automatic new_req(input int p);
        req(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            AW'(12'h100 + $urandom_range(0, 15)), $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_lock = 0; cnt = 0; last = 1;
        ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
        req(0, 0, 0, '0, '0);
        req(1, 0, 0, '0, '0);
        m1_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference: returns granted port (0/1) or -1 for an idle cycle.
    function automatic int model_grant();
        if (in_lock && m1.valid && m1_lock && cnt < LM) return 1;
        if (m0.valid && m1.valid) return last ? 0 : 1;
        if (m0.valid) return 0;
        if (m1.valid) return 1;
        return -1;
    endfunction

    task automatic model_commit(input int g);
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            stay;
        stay = in_lock && m1.valid && m1_lock && cnt < LM;
        ev0 = 0; ev1 = 0;
        if (g >= 0) begin
            w = (g == 1) ? m1.we : m0.we;
            a = (g == 1) ? m1.addr : m0.addr;
            d = (g == 1) ? m1.wdata : m0.wdata;
            if (w) mmem[int'(a)] = d;
            else if (g == 0) begin ev0 = 1; ed0 = mmem[int'(a)]; end
            else begin ev1 = 1; ed1 = mmem[int'(a)]; end
            last = (g == 1);
        end
        if (stay) cnt++;
        else if (g == 1 && m1_lock) begin in_lock = 1; cnt = 1; end
        else begin in_lock = 0; cnt = 0; end
    endtask

    task automatic cycle(output int g);
        logic          w, ew, er;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        g  = model_grant();
        w  = (g == 1) ? m1.we : m0.we;
        a  = (g == 1) ? m1.addr : m0.addr;
        d  = (g == 1) ? m1.wdata : m0.wdata;
        ew = (g >= 0) && w;
        er = (g >= 0) && !w;
        chk_bus("bus", g == 0, g == 1, ew, ew ? a : '0, ew ? d : '0, er, er ? a : '0);
        @(posedge clk);
        model_commit(g);
        #1;
        chk("rsp", {m0.rvalid, m0.rdata, m1.rvalid, m1.rdata}, {ev0, ed0, ev1, ed1});
    endtask

    initial begin
        int g;
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b01};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b10};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b01};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'b10};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b01};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'b01};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 2'b01};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'b10};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 2'b01};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 2'b10};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 2'b01};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b00};

        do_reset();
        chk("reset_rsp", {m0.rvalid, m0.rdata, m1.rvalid, m1.rdata}, '0);
        req(0, 1, 1, 12'h010, 32'hDEADBEEF);
        chk_bus("m0_write", 1, 0, 1, 12'h010, 32'hDEADBEEF, 0, '0);
        tick();
        req(0, 1, 0, 12'h010, '0);
        chk_bus("m0_read", 1, 0, 0, '0, '0, 1, 12'h010);
        tick();
        chk("m0_rsp", {m0.rvalid, m0.rdata}, {1'b1, 32'hDEADBEEF});
        req(0, 0, 0, '0, '0);
        tick();
        chk("m0_rsp_hold", {m0.rvalid, m0.rdata}, {1'b0, 32'hDEADBEEF});

        do_reset();
        for (int i = 0; i < 18; i++) begin
            req(0, tbl[i].v0, 0, 12'h010, '0);
            req(1, tbl[i].v1, 0, 12'h010, '0);
            m1_lock = tbl[i].lk;
            @(negedge clk);
            chk($sformatf("grant[%0d]", i), {m1.ready, m0.ready}, tbl[i].g);
            tick();
        end

        do_reset();
        req(0, 1, 0, 12'h010, '0);
        req(1, 1, 0, 12'h010, '0);
        m1_lock = 1'b1;
        repeat (3) tick();
        chk("burst_rsp", {m1.rvalid, m1.rdata}, {1'b1, 32'hDEADBEEF});
        rst_n = 1'b0;
        #1;
        chk("rst_async", {m0.ready, m1.ready, wen, ren, m0.rvalid, m1.rvalid, m1.rdata}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_bus("rst_arb", 1, 0, 0, '0, '0, 1, 12'h010);
        chk("rst_rv", {m0.rvalid, m1.rvalid}, '0);

        do_reset();
        req(0, 1, 1, 12'h020, 32'h11111111);
        tick();
        do_reset();
        req(0, 1, 0, 12'h020, '0);
        req(1, 1, 1, 12'h020, 32'h55);
        chk_bus("coll_m0", 1, 0, 0, '0, '0, 1, 12'h020);
        tick();
        chk("coll_old", {m0.rvalid, m0.rdata}, {1'b1, 32'h11111111});
        req(0, 0, 0, '0, '0);
        chk_bus("coll_m1", 0, 1, 1, 12'h020, 32'h55, 0, '0);
        tick();
        req(1, 0, 0, '0, '0);
        req(0, 1, 0, 12'h020, '0);
        tick();
        chk("coll_new", {m0.rvalid, m0.rdata}, {1'b1, 32'h55});

        do_reset();
        for (int i = 0; i < 16; i++) begin
            req(0, 1, 1, AW'(12'h100 + i), $urandom);
            cycle(g);
        end
        new_req(0);
        new_req(1);
        for (int i = 0; i < 300; i++) begin
            cycle(g);
            if (g == 0 || !m0.valid) new_req(0);
            if (g == 1 || !m1.valid) new_req(1);
            m1_lock = $urandom_range(0, 3) != 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width; SHALL match the data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LOCK_MAX, default 16, maximum consecutive m1 grants under lock; legal range 1..255.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 mX_valid  in  1  request valid, X=0 (core load/store) and X=1 (DMA/debug).
REQ-008 mX_we  in  1  1=write, 0=read.
REQ-009 mX_addr  in  ADDR_W  word address.
REQ-010 mX_wdata  in  DATA_W  write data.
REQ-011 m1_lock  in  1  m1 requests back-to-back grants (burst).
REQ-012 mX_ready  out  1  request accepted this cycle.
REQ-013 mX_rvalid  out  1  read data valid, one cycle after read acceptance.
REQ-014 mX_rdata  out  DATA_W  read data, held until the next read response on that port.
REQ-015 dmem_wen, dmem_waddr, dmem_wdata  out  1/ADDR_W/DATA_W  memory write port.
REQ-016 dmem_ren, dmem_raddr  out  1/ADDR_W  memory read port.
REQ-017 dmem_rdata  in  DATA_W  combinational memory read data, same cycle.

Function
REQ-018 Handshake: a request transfers when mX_valid && mX_ready; at most one port is ready per cycle.
REQ-019 mX_ready SHALL be combinational from the valids and the state, with no dependence on mX_ready itself.
REQ-020 Requesters SHALL hold valid, we, addr and wdata stable until ready.
REQ-021 FSM states: ARB and LOCK1.
REQ-022 ARB, one port valid: that port is granted.
REQ-023 ARB, both ports valid: the port other than last_grant is granted (round-robin); last_grant resets to 1, so m0 wins the first contention.
REQ-024 ARB -> LOCK1 when m1 is granted with m1_lock=1; lock_cnt is set to 1.
REQ-025 LOCK1: m1 is granted whenever m1_valid, regardless of m0; lock_cnt increments on each m1 grant.
REQ-026 LOCK1 -> ARB when m1_lock=0, when m1_valid=0, or when lock_cnt==LOCK_MAX; in each case m0 is granted that cycle if m0 is valid.
REQ-027 On exit by cap (lock_cnt==LOCK_MAX), last_grant=1; m1 SHALL NOT re-enter LOCK1 until m0 has been granted or m0_valid is low.
REQ-028 A granted write drives dmem_wen=1 with the granted addr/wdata; a granted read drives dmem_ren=1 and dmem_raddr; otherwise all dmem_* outputs are 0.
REQ-029 A granted read SHALL register dmem_rdata into mX_rdata, with mX_rvalid=1 for exactly the next cycle.
REQ-030 Only one dmem operation per cycle, so write-bypass collisions cannot be created by the arbiter.
REQ-031 last_grant updates on every grant.
REQ-032 lock_cnt is 8 bits and SHALL saturate and never wrap.

Reset
REQ-033 While rst_n=0, and asynchronously on its assertion: state=ARB, last_grant=1, lock_cnt=0, mX_rvalid=0, mX_rdata=0.
REQ-034 While rst_n=0, ready and dmem_* outputs are 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst; no pending rvalid survives reset.

Structure
REQ-036 Package dmem_pkg SHALL hold the arb_state_e enum (ARB, LOCK1) and the default ADDR_W/DATA_W constants.
REQ-037 Sub-module rr_arb2 SHALL provide a 2-way round-robin grant with a last_grant input.
REQ-038 All other logic is flat.

Verification
REQ-039 Reset, then m0 writes 0xDEADBEEF to 0x010 and reads 0x010 -> m0_ready=1 each cycle; m0_rvalid=1 one cycle after the read with m0_rdata=0xDEADBEEF.
REQ-040 Both valid every cycle, no lock -> grants alternate m0,m1,m0,m1, starting with m0.
REQ-041 m1_lock=1 with m0 and m1 continuously valid, LOCK_MAX=4 -> exactly 4 consecutive m1 grants, then an m0 grant.
REQ-042 m1 burst, lock dropped after 2 grants -> m0 granted in the next cycle.
REQ-043 rst_n asserted while in LOCK1 with a read pending -> next cycle state=ARB, all rvalid=0, dmem_ren=0.
REQ-044 m0 reads 0x020 while m1 writes 0x55 to 0x020 in the same cycle -> serialized per REQ-023, and the read returns the value consistent with grant order.
